// File: rtl/q_pkg.sv
// ---------------------------------------------------------------------------
// q_pkg
// Shared types and fixed-point helpers for the Q-learning update engine.
//   q_state_e : engine FSM states
//   act_w()   : width of the action field for a given action count
//   fx_one()  : fixed-point 1.0 for a given number of fractional bits
//   sat_hi()  : largest signed value representable in data_w bits
//   sat_lo()  : smallest signed value representable in data_w bits
// ---------------------------------------------------------------------------
package q_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RD_NEXT,
        RD_CUR,
        CALC,
        RESP
    } q_state_e;

    // A single action still needs a one-bit field to keep ports legal.
    function automatic int act_w(input int n_actions);
        return (n_actions > 1) ? $clog2(n_actions) : 1;
    endfunction

    function automatic longint fx_one(input int frac_w);
        return longint'(1) << frac_w;
    endfunction

    function automatic longint sat_hi(input int data_w);
        return (longint'(1) << (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int data_w);
        return -(longint'(1) << (data_w - 1));
    endfunction

endpackage

// File: rtl/q_max_tree.sv
// ---------------------------------------------------------------------------
// q_max_tree
// Combinational N-input signed maximum with argmax. Ties resolve to the
// lowest index. The parent registers the outputs.
//   values  : N signed operands
//   max_val : largest operand
//   max_idx : index of the first operand equal to max_val
// ---------------------------------------------------------------------------
module q_max_tree #(
    parameter int N      = 9,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic signed [DATA_W-1:0] values [N],
    output logic signed [DATA_W-1:0] max_val,
    output logic        [IDX_W-1:0]  max_idx
);

    // NOTE: blocking assignments in combinational logic, so each loop step
    // sees the running maximum left by the step before it.
    always_comb begin
        max_val = values[0];
        max_idx = '0;
        for (int i = 1; i < N; i++) begin
            // Strict compare keeps the earlier (lower) index on a tie.
            if (values[i] > max_val) begin
                max_val = values[i];
                max_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/q_update_engine.sv
// ---------------------------------------------------------------------------
// q_update_engine
// Handshaked Q-learning update engine. Holds the Q table as N_ACTIONS banks
// of 2^STATE_W entries, accepts one transition per request, applies the
// Bellman update in signed fixed point, writes it back and returns the new
// Q value with the greedy action for next_state.
//
// Ports
//   clock, reset_n          : clock and async active-low reset
//   in_valid / in_ready     : request handshake
//   state, next_state       : current and successor state (table address)
//   action                  : action taken (>= N_ACTIONS flags out_err)
//   reward, gamma, alfa     : signed fixed point, FRAC_W fractional bits
//   terminal                : forces maxQ(next_state) to zero
//   clear_req / clear_busy  : start / progress of the table zeroing sweep
//   out_valid / out_ready   : response handshake
//   q_new, best_action      : updated Q(state,action), argmax Q(next_state,.)
//   out_err                 : request carried an illegal action
//
// Build option
//   Q_UPDATE_SAT_EN : saturate td, delta and q_new to DATA_W signed range;
//                     when undefined the final result wraps to DATA_W bits.
// ---------------------------------------------------------------------------
module q_update_engine
    import q_pkg::*;
#(
    parameter  int N_ACTIONS = 9,
    parameter  int STATE_W   = 18,
    parameter  int DATA_W    = 16,
    parameter  int FRAC_W    = 8,
    localparam int ACT_W     = act_w(N_ACTIONS)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state,
    input  logic [STATE_W-1:0] next_state,
    input  logic [ACT_W-1:0]   action,
    input  logic [DATA_W-1:0]  reward,
    input  logic [DATA_W-1:0]  gamma,
    input  logic [DATA_W-1:0]  alfa,
    input  logic               terminal,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  q_new,
    output logic [ACT_W-1:0]   best_action,
    output logic               out_err
);

    localparam int W2    = 2 * DATA_W + 2;
    localparam int DEPTH = 2 ** STATE_W;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [STATE_W-1:0] next_state;
        logic [ACT_W-1:0]   action;
        logic [DATA_W-1:0]  reward;
        logic [DATA_W-1:0]  gamma;
        logic [DATA_W-1:0]  alfa;
        logic               terminal;
    } req_t;

`ifdef Q_UPDATE_SAT_EN
    localparam logic signed [W2-1:0] SAT_HI = W2'(sat_hi(DATA_W));
    localparam logic signed [W2-1:0] SAT_LO = W2'(sat_lo(DATA_W));

    function automatic logic signed [W2-1:0] fit(input logic signed [W2-1:0] x);
        if (x > SAT_HI) return SAT_HI;
        if (x < SAT_LO) return SAT_LO;
        return x;
    endfunction
`else
    function automatic logic signed [W2-1:0] fit(input logic signed [W2-1:0] x);
        return x;
    endfunction
`endif

    q_state_e                  fsm, fsm_nxt;
    req_t                      req;
    logic                      req_err;
    logic [STATE_W-1:0]        clear_addr;
    logic                      resp_first;
    logic signed [DATA_W-1:0]  max_q;

    logic [STATE_W-1:0]        bank_addr;
    logic [DATA_W-1:0]         bank_wdata;
    logic [N_ACTIONS-1:0]      bank_we;
    logic signed [DATA_W-1:0]  rd_data [N_ACTIONS];

    logic signed [DATA_W-1:0]  tree_max;
    logic [ACT_W-1:0]          tree_idx;
    logic signed [DATA_W-1:0]  q_cur;
    logic signed [W2-1:0]      q_x, gm, td, ad, delta, sum;
    logic [DATA_W-1:0]         q_calc;

    assign in_ready   = (fsm == IDLE);
    assign clear_busy = (fsm == CLEAR);
    assign out_valid  = (fsm == RESP);
    assign req_err    = (32'(req.action) >= N_ACTIONS);

    // NOTE: defaults are assigned before the case so every path drives
    // fsm_nxt and no latch is inferred.
    always_comb begin
        fsm_nxt = fsm;
        unique case (fsm)
            IDLE:    if (clear_req)            fsm_nxt = CLEAR;
                     else if (in_valid)        fsm_nxt = RD_NEXT;
            CLEAR:   if (clear_addr == '1)     fsm_nxt = IDLE;
            RD_NEXT:                           fsm_nxt = RD_CUR;
            RD_CUR:                            fsm_nxt = CALC;
            CALC:                              fsm_nxt = RESP;
            RESP:    if (out_ready)            fsm_nxt = IDLE;
            default:                           fsm_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm         <= IDLE;
            req         <= '0;
            clear_addr  <= '0;
            resp_first  <= 1'b0;
            max_q       <= '0;
            q_new       <= '0;
            best_action <= '0;
            out_err     <= 1'b0;
        end else begin
            fsm <= fsm_nxt;

            if (fsm == IDLE && in_valid && !clear_req)
                req <= '{state, next_state, action, reward, gamma, alfa, terminal};

            if (fsm == CLEAR) clear_addr <= clear_addr + 1'b1;
            else              clear_addr <= '0;

            if (fsm == RD_CUR) begin
                max_q       <= req.terminal ? '0 : tree_max;
                best_action <= tree_idx;
            end

            if (fsm == CALC) begin
                q_new      <= q_calc;
                out_err    <= req_err;
                resp_first <= 1'b1;
            end else if (fsm == RESP) begin
                resp_first <= 1'b0;
            end
        end
    end

    // One shared address per bank: the sweep in CLEAR, next_state for the
    // max read, otherwise state (current-Q read and the write-back).
    always_comb begin
        bank_addr  = (fsm == RD_NEXT) ? req.next_state : req.state;
        bank_wdata = q_new;
        bank_we    = '0;
        if (fsm == CLEAR) begin
            bank_addr  = clear_addr;
            bank_wdata = '0;
            bank_we    = '1;
        end else if (fsm == RESP && resp_first && !out_err) begin
            for (int b = 0; b < N_ACTIONS; b++)
                bank_we[b] = (req.action == ACT_W'(b));
        end
    end

    for (genvar b = 0; b < N_ACTIONS; b++) begin : g_bank
        logic signed [DATA_W-1:0] mem [DEPTH];
        logic signed [DATA_W-1:0] rd_q;

        // NOTE: the RAM array has no reset; contents are undefined until a
        // clear sweep, which keeps it mappable to block RAM.
        always_ff @(posedge clock) begin
            if (bank_we[b]) mem[bank_addr] <= bank_wdata;
            rd_q <= mem[bank_addr];
        end

        assign rd_data[b] = rd_q;
    end

    q_max_tree #(
        .N      (N_ACTIONS),
        .DATA_W (DATA_W),
        .IDX_W  (ACT_W)
    ) u_max_tree (
        .values  (rd_data),
        .max_val (tree_max),
        .max_idx (tree_idx)
    );

    // Illegal actions match no bank, so Q reads as zero.
    always_comb begin
        q_cur = '0;
        for (int b = 0; b < N_ACTIONS; b++)
            if (req.action == ACT_W'(b)) q_cur = rd_data[b];
    end

    // Bellman update; >>> on signed operands floors toward minus infinity.
    always_comb begin
        q_x    = W2'(q_cur);
        gm     = W2'($signed(req.gamma)) * W2'(max_q);
        td     = fit(W2'($signed(req.reward)) + (gm >>> FRAC_W) - q_x);
        ad     = W2'($signed(req.alfa)) * td;
        delta  = fit(ad >>> FRAC_W);
        sum    = fit(q_x + delta);
        q_calc = DATA_W'(sum);
    end

endmodule

// File: tb/tb_q_update_engine.sv
// ---------------------------------------------------------------------------
// tb_q_update_engine
// Self-checking bench for q_update_engine (STATE_W=4, 9 actions, Q8.8).
// A plain-arithmetic table model predicts every response; one compare
// process checks each RESP cycle, and the directed scenarios pin literals.
// Honours Q_UPDATE_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_q_update_engine;

    localparam int NA = 9;
    localparam int SW = 4;
    localparam int NS = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  state = '0;
    logic [3:0]  next_state = '0;
    logic [3:0]  action = '0;
    logic [15:0] reward = '0;
    logic [15:0] gamma = '0;
    logic [15:0] alfa = '0;
    logic        terminal = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] q_new;
    logic [3:0]  best_action;
    logic        out_err;

    q_update_engine #(
        .N_ACTIONS (NA),
        .STATE_W   (SW),
        .DATA_W    (16),
        .FRAC_W    (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .state       (state),
        .next_state  (next_state),
        .action      (action),
        .reward      (reward),
        .gamma       (gamma),
        .alfa        (alfa),
        .terminal    (terminal),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q_new       (q_new),
        .best_action (best_action),
        .out_err     (out_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int model_q [NA][NS];

    typedef struct {
        logic [15:0] q;
        logic [3:0]  best;
        logic        err;
        int          s;
        int          a;
    } exp_t;
    exp_t exp_q [$];

    function automatic longint wrapw(input longint x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint fit_m(input longint x);
`ifdef Q_UPDATE_SAT_EN
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
`endif
        return x;
    endfunction

    function automatic longint bellman(input longint q, input longint mq,
                                       input longint r, input longint g, input longint al);
        longint gm, td, d, s;
        gm = wrapw(g * mq, 34) >>> 8;
        td = fit_m(wrapw(r + gm - q, 34));
        d  = fit_m(wrapw(wrapw(al * td, 34) >>> 8, 34));
        s  = fit_m(wrapw(q + d, 34));
        return wrapw(s, 16);
    endfunction

    function automatic exp_t predict(input int s, input int a, input int ns,
                                     input logic [15:0] r, input logic [15:0] g,
                                     input logic [15:0] al, input logic t);
        exp_t e;
        int mx, bi, qc;
        mx = model_q[0][ns];
        bi = 0;
        for (int k = 1; k < NA; k++)
            if (model_q[k][ns] > mx) begin mx = model_q[k][ns]; bi = k; end
        if (t) mx = 0;
        qc = (a < NA) ? model_q[a][s] : 0;
        e.q    = 16'(bellman(qc, mx, longint'($signed(r)), longint'($signed(g)),
                             longint'($signed(al))));
        e.best = 4'(bi);
        e.err  = (a >= NA);
        e.s    = s;
        e.a    = a;
        return e;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: out_valid with no pending request at %0t", $time);
            end else begin
                check("q_new", 32'(q_new), 32'(exp_q[0].q));
                check("best_action", 32'(best_action), 32'(exp_q[0].best));
                check("out_err", 32'(out_err), 32'(exp_q[0].err));
                check("in_ready_in_resp", 32'(in_ready), 32'(0));
                if (out_ready) begin
                    if (!exp_q[0].err)
                        model_q[exp_q[0].a][exp_q[0].s] = int'($signed(exp_q[0].q));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks (called just after a rising edge) ----------------
    logic [15:0] last_q;
    logic [3:0]  last_best;
    logic        last_err;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        check("in_ready_wait", 32'(in_ready), 32'(1));
    endtask

    task automatic do_req(input int s, input int a, input int ns, input logic [15:0] r,
                          input logic [15:0] g, input logic [15:0] al, input logic t,
                          input int stall);
        int lat;
        out_ready = (stall == 0);
        wait_ready();
        exp_q.push_back(predict(s, a, ns, r, g, al, t));
        in_valid = 1'b1; state = 4'(s); action = 4'(a); next_state = 4'(ns);
        reward = r; gamma = g; alfa = al; terminal = t;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check("latency", 32'(lat), 32'(4));
        last_q = q_new; last_best = best_action; last_err = out_err;
        if (stall > 0) begin
            clear_req = 1'b1;       // must be ignored outside IDLE
            tick();
            clear_req = 1'b0;
            repeat (stall - 1) tick();
            out_ready = 1'b1;
        end
        tick();
        if (stall > 0) check("clear_ignored", 32'(clear_busy), 32'(0));
    endtask

    task automatic do_clear(input logic with_valid);
        int cnt = 0;
        wait_ready();
        clear_req = 1'b1;
        in_valid  = with_valid;
        tick();
        clear_req = 1'b0;
        in_valid  = 1'b0;
        check("clear_busy_start", 32'(clear_busy), 32'(1));
        check("clear_in_ready", 32'(in_ready), 32'(0));
        while (clear_busy && cnt < 100) begin tick(); cnt++; end
        check("clear_cycles", 32'(cnt), 32'(NS));
        check("clear_no_resp", 32'(out_valid), 32'(0));
        for (int a = 0; a < NA; a++)
            for (int s = 0; s < NS; s++) model_q[a][s] = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_clear_busy", 32'(clear_busy), 32'(0));
        check("rst_q_new", 32'(q_new), 32'(0));
        check("rst_best", 32'(best_action), 32'(0));
        check("rst_err", 32'(out_err), 32'(0));
        tick();

        // clear_req wins over a simultaneous request
        do_clear(1'b1);

        do_req(1, 2, 3, 16'h0100, 16'h0080, 16'h0080, 1'b0, 0);
        check("s1_q", 32'(last_q), 32'h0080);
        do_req(1, 2, 3, 16'h0100, 16'h0080, 16'h0080, 1'b0, 0);
        check("s2_q", 32'(last_q), 32'h00C0);
        do_req(0, 0, 1, 16'h0000, 16'h0080, 16'h0100, 1'b0, 0);
        check("s3_q", 32'(last_q), 32'h0060);
        check("s3_best", 32'(last_best), 32'd2);

        do_req(5, 0, 0, 16'h7F00, 16'h0000, 16'h0100, 1'b0, 0);
        check("seed_q", 32'(last_q), 32'h7F00);
        do_req(6, 0, 5, 16'h7F00, 16'h0100, 16'h0100, 1'b0, 0);
`ifdef Q_UPDATE_SAT_EN
        check("sat_q", 32'(last_q), 32'h7FFF);
`else
        check("wrap_q", 32'(last_q), 32'hFE00);
`endif
        do_req(6, 0, 5, 16'h7F00, 16'h0100, 16'h0100, 1'b1, 0);
        check("terminal_q", 32'(last_q), 32'h7F00);
        check("terminal_best", 32'(last_best), 32'd0);
        do_req(6, 9, 5, 16'h7F00, 16'h0100, 16'h0100, 1'b0, 0);
        check("illegal_err", 32'(last_err), 32'd1);
        // Q(6,.) must still hold 0x7F00 in bank 0 only
        do_req(7, 1, 6, 16'h0000, 16'h0100, 16'h0100, 1'b0, 0);
        check("probe_q", 32'(last_q), 32'h7F00);
        check("probe_best", 32'(last_best), 32'd0);
        check("probe_err", 32'(last_err), 32'd0);

        // response stalled for 10 cycles; compare process checks each cycle
        do_req(2, 3, 4, 16'h0200, 16'h0080, 16'h0040, 1'b0, 10);

        // reset while in RD_CUR: the pending write must be dropped
        wait_ready();
        in_valid = 1'b1; state = 4'd1; action = 4'd2; next_state = 4'd3;
        reward = 16'h4000; gamma = 16'h0100; alfa = 16'h0100; terminal = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_q_new", 32'(q_new), 32'(0));
        tick();
        reset_n = 1'b1;
        tick();
        do_req(0, 4, 1, 16'h0000, 16'h0100, 16'h0100, 1'b0, 0);
        check("midrst_probe_q", 32'(last_q), 32'h00C0);
        check("midrst_probe_best", 32'(last_best), 32'd2);

        // randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic [15:0] r, g, al;
            if (i % 50 == 49) do_clear(1'b0);
            r  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
            g  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 256));
            al = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 256));
            do_req($urandom_range(0, 15), $urandom_range(0, 11), $urandom_range(0, 15),
                   r, g, al, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/q_update_engine.md
# q_update_engine

Parametrised, self-sequencing Q-learning update engine for the tic-tac-toe agent. It holds the full Q table as `N_ACTIONS` internal banks and accepts one transition (state, action, next_state, reward, terminal) per valid/ready handshake. For each transition it computes the Bellman update in signed fixed point, writes the result back, and returns the new Q value plus the greedy action for `next_state`. It replaces the fixed 9-action, free-running datapath with a handshaked FSM that has generic widths and a table-clear sweep.

## Interface
Parameters:
- `N_ACTIONS`, 9: number of actions, which is also the number of table banks.
- `STATE_W`, 18: state/address width; each bank holds 2^STATE_W entries.
- `DATA_W`, 16: width of Q, reward, gamma and alfa (signed two's complement).
- `FRAC_W`, 8: number of fractional bits in all fixed-point operands.

Ports (the action port is `ACT_W`=$clog2(N_ACTIONS) bits wide):
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid` / `in_ready`  in/out  1  request handshake.
- `state`, `next_state`  in  STATE_W  current and successor state.
- `action`  in  ACT_W  action taken.
- `reward`, `gamma`, `alfa`  in  DATA_W  signed fixed point.
- `terminal`  in  1  when set, forces maxQ(next_state) to 0.
- `clear_req`  in  1  pulse that starts zeroing the whole table.
- `clear_busy`  out  1  high while the clear sweep runs.
- `out_valid` / `out_ready`  out/in  1  response handshake.
- `q_new`  out  DATA_W  updated Q(state, action).
- `best_action`  out  ACT_W  argmax over actions of Q(next_state, ·).
- `out_err`  out  1  set when `action` ≥ N_ACTIONS.

## Operation
- FSM states: IDLE, CLEAR, RD_NEXT, RD_CUR, CALC, RESP.
- IDLE:
  - `in_ready`=1.
  - `clear_req` takes priority over `in_valid` in the same cycle and moves to CLEAR.
  - An accepted request is registered and moves to RD_NEXT.
- RD_NEXT: all banks are read at `next_state`.
- RD_CUR:
  - A max tree reduces the bank outputs; the registered result is maxQ and `best_action`.
  - Ties resolve to the lowest index.
  - `terminal` forces maxQ=0; `best_action` is still computed.
  - Bank `action` is read at `state`.
- CALC, with Q = Q(state, action):
  - td = reward + ((gamma·maxQ) >>> FRAC_W) − Q
  - delta = (alfa·td) >>> FRAC_W
  - q_new = Q + delta
  - Intermediates are 2·DATA_W+2 bits wide. `>>>` is an arithmetic shift that truncates toward −∞.
  - The result is registered.
- RESP:
  - Bank `action` at `state` is written with `q_new` in the first RESP cycle only.
  - `out_valid`=1 and outputs stay stable until `out_ready`, then the FSM returns to IDLE.
- Illegal `action` (≥ N_ACTIONS): Q is read as 0, no write occurs, `out_err`=1, and `best_action` is still valid.
- `state`==`next_state`: the max is taken from pre-update contents.
- CLEAR: writes 0 to every bank, one address per cycle from 0 to 2^STATE_W−1, then returns to IDLE. `in_ready`=0 throughout.
- Table contents after reset are undefined; firmware issues `clear_req` first.

## Timing
- Reset values: FSM=IDLE, `in_ready`=1 (combinational from IDLE), `out_valid`=0, `clear_busy`=0, `q_new`=0, `best_action`=0, `out_err`=0.
- Bank reads are synchronous with 1-cycle latency.
- Request accepted at cycle 0 → RD_NEXT at 1, RD_CUR at 2, CALC at 3, RESP (`out_valid`) at 4; the write commits at the cycle-4 edge.
- Throughput is one request per 5 cycles when `out_ready` is held high. `out_ready` low stalls the engine in RESP with no repeated write.
- CLEAR lasts 2^STATE_W cycles; `clear_busy` goes high the cycle after `clear_req` and low on return to IDLE.
- `clear_req` outside IDLE is ignored.
- Reset mid-operation: the FSM returns to IDLE immediately, any pending write is dropped, and a clear sweep aborts, leaving the table partially cleared.

## Configuration
- `Q_UPDATE_SAT_EN` defined:
  - td, delta and q_new each saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1] before truncation to DATA_W.
- `Q_UPDATE_SAT_EN` undefined:
  - Only the final result is truncated to DATA_W bits (two's-complement wrap), which gives fewer gates.

## Structure
- Package `q_pkg`:
  - FSM state enum.
  - `ACT_W` derivation function.
  - Fixed-point helper constants: one = 1<<FRAC_W, plus the saturation limits.
- Sub-module `q_max_tree`: a parametrised N-input signed maximum/argmax with lowest-index tie-break. It is combinational and registered by the parent.
- The banks are inferred inside the parent as an array of N_ACTIONS single-port RAMs (sync read, one write).

## Test plan
All scenarios use STATE_W=4, N_ACTIONS=9, Q8.8.
- Clear, then request s=1, a=2, ns=3, reward=0x0100, gamma=0x0080, alfa=0x0080 → `q_new`=0x0080, `out_valid` at cycle 4.
- Repeat the identical request → `q_new`=0x00C0.
- Request s=0, a=0, ns=1, reward=0, gamma=0x0080, alfa=0x0100 → maxQ=0x00C0, `q_new`=0x0060, `best_action`=2.
- Seed Q(5,0)=0x7F00 (reward=0x7F00, alfa=0x0100, gamma=0). Then request s=6, a=0, ns=5, reward=0x7F00, gamma=0x0100, alfa=0x0100 → 0x7FFF with `Q_UPDATE_SAT_EN`, 0xFE00 without.
- Repeat the seeded request with `terminal`=1 → `q_new`=0x7F00; with `action`=9 → `out_err`=1 and Q(6,·) unchanged.
- Hold `out_ready`=0 for 10 cycles → outputs stable and a single write. Assert reset in RD_CUR → `out_valid`=0, `in_ready`=1, and no write.
